// File: rtl/flappy_render.sv
// Flappy Brick pixel renderer and per-frame game-state engine.
// Consumes VGA raster counters and produces a registered 3-3-2 RGB pixel.
module flappy_render #(
  parameter int BRICK_X    = 200,
  parameter int BRICK_SIZE = 16,
  parameter int PIPE_W     = 40,
  parameter int GAP_H      = 120,
  parameter int SCROLL     = 2,
  parameter int GRAVITY    = 1,
  parameter int FLAP_VEL   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] hc,
  input  logic [9:0] vc,
  input  logic       videoen,
  input  logic       flap,
  output logic [7:0] rgb,
  output logic [7:0] score,
  output logic       dead
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_DEAD = 2'd2;

  localparam logic signed [10:0] Y_START   = 11'sd232;
  localparam logic signed [10:0] Y_MAX     = 11'(480 - BRICK_SIZE);
  localparam logic signed [10:0] B_SIZE    = 11'(BRICK_SIZE);
  localparam logic signed [5:0]  V_MAX     = 6'sd15;
  localparam logic signed [5:0]  V_GRAV    = 6'(GRAVITY);
  localparam logic signed [5:0]  V_FLAP    = 6'(-FLAP_VEL);
  localparam logic [9:0]         PX_START  = 10'd640;
  localparam logic [9:0]         PX_SCROLL = 10'(SCROLL);
  localparam logic [9:0]         BX_LO     = 10'(BRICK_X);
  localparam logic [9:0]         BX_HI     = 10'(BRICK_X + BRICK_SIZE);
  localparam logic [10:0]        P_W       = 11'(PIPE_W);
  localparam logic [9:0]         G_H       = 10'(GAP_H);
  localparam logic [8:0]         GAP_START = 9'd180;
  localparam logic [8:0]         GAP_BASE  = 9'd60;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  logic [1:0]         state_r;
  logic signed [10:0] brick_y_r;
  logic signed [5:0]  vel_r;
  logic [9:0]         pipe_x_r;
  logic [8:0]         gap_y_r;
  logic [7:0]         lfsr_r;
  logic [7:0]         score_r;
  logic [7:0]         rgb_r;
  logic               hit_r;
  logic               flap_pend_r;
  logic               sync0_r;
  logic               sync1_r;
  logic               sync2_r;

  logic [9:0]         x_s;
  logic [9:0]         y_s;
  logic signed [10:0] y_sg_s;
  logic               tick_s;
  logic               edge_s;
  logic               restart_s;
  logic signed [5:0]  vel_inc_s;
  logic signed [5:0]  vel_new_s;
  logic signed [10:0] y_new_s;
  logic               die_s;
  logic               brick_px_s;
  logic               pipe_px_s;

  // Raster decode, physics step and pixel classification
  always_comb begin
    x_s        = hc - 10'd144;
    y_s        = vc - 10'd31;
    y_sg_s     = signed'({1'b0, y_s});
    tick_s     = (hc == 10'd799) && (vc == 10'd520);
    edge_s     = sync1_r & ~sync2_r;
    restart_s  = (state_r == S_DEAD) && edge_s;
    vel_inc_s  = (vel_r > (V_MAX - V_GRAV)) ? V_MAX : (vel_r + V_GRAV);
    vel_new_s  = flap_pend_r ? V_FLAP : vel_inc_s;
    y_new_s    = brick_y_r + {{5{vel_new_s[5]}}, vel_new_s};
    die_s      = (y_new_s < 11'sd0) || (y_new_s > Y_MAX) || hit_r;
    brick_px_s = (x_s >= BX_LO) && (x_s < BX_HI) &&
                 (y_sg_s >= brick_y_r) && (y_sg_s < (brick_y_r + B_SIZE));
    // Pipe columns clip at the right screen edge; the gap is open vertically
    pipe_px_s  = ({1'b0, x_s} >= {1'b0, pipe_x_r}) &&
                 ({1'b0, x_s} < ({1'b0, pipe_x_r} + P_W)) && (x_s < 10'd640) &&
                 ((y_s < {1'b0, gap_y_r}) || (y_s >= ({1'b0, gap_y_r} + G_H)));
  end

  // Game state, flap synchronizer, LFSR and collision latch
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      brick_y_r   <= Y_START;
      vel_r       <= 6'sd0;
      pipe_x_r    <= PX_START;
      gap_y_r     <= GAP_START;
      lfsr_r      <= 8'hA5;
      score_r     <= 8'd0;
      hit_r       <= 1'b0;
      flap_pend_r <= 1'b0;
      sync0_r     <= 1'b0;
      sync1_r     <= 1'b0;
      sync2_r     <= 1'b0;
    end else begin
      sync0_r <= flap;
      sync1_r <= sync0_r;
      sync2_r <= sync1_r;
      lfsr_r  <= lfsr_next(lfsr_r);
      hit_r   <= (tick_s || restart_s) ? 1'b0 : (hit_r | (videoen & brick_px_s & pipe_px_s));
      case (state_r)
        S_IDLE: begin
          if (edge_s) begin
            state_r     <= S_PLAY;
            flap_pend_r <= 1'b1;
          end
        end
        S_PLAY: begin
          if (tick_s) begin
            vel_r     <= vel_new_s;
            brick_y_r <= y_new_s;
            if (pipe_x_r < PX_SCROLL) begin
              pipe_x_r <= PX_START;
              gap_y_r  <= GAP_BASE + {1'b0, lfsr_r};
              score_r  <= score_r + 8'd1;
            end else begin
              pipe_x_r <= pipe_x_r - PX_SCROLL;
            end
            state_r     <= die_s ? S_DEAD : S_PLAY;
            // An edge landing on the tick itself is kept for the next tick
            flap_pend_r <= edge_s;
          end else if (edge_s) begin
            flap_pend_r <= 1'b1;
          end
        end
        S_DEAD: begin
          if (edge_s) begin
            state_r     <= S_IDLE;
            brick_y_r   <= Y_START;
            vel_r       <= 6'sd0;
            pipe_x_r    <= PX_START;
            gap_y_r     <= GAP_START;
            score_r     <= 8'd0;
            flap_pend_r <= 1'b0;
          end
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end

  // Registered colour with brick over pipe over background priority
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_r <= 8'h00;
    end else if (!videoen) begin
      rgb_r <= 8'h00;
    end else if (brick_px_s) begin
      rgb_r <= 8'hE0;
    end else if (pipe_px_s) begin
      rgb_r <= 8'h1C;
    end else if (state_r == S_DEAD) begin
      rgb_r <= 8'h49;
    end else begin
      rgb_r <= 8'h5B;
    end
  end

  assign rgb   = rgb_r;
  assign score = score_r;
  assign dead  = (state_r == S_DEAD);

endmodule

// File: doc/flappy_render.md
# flappy_render

Pixel renderer and game-state engine for the Flappy Brick display path. It sits directly downstream of the VGA sync generator and consumes its 800x521 raster counters (`hc`, `vc`) and `videoen`. Once per frame it updates the brick physics, pipe scrolling and score. Every pixel clock it produces a registered 8-bit RGB (3-3-2) colour for the 640x480 active area.

## Interface
- `BRICK_X`, 200: brick left edge, active-area x.
- `BRICK_SIZE`, 16: brick width and height in pixels.
- `PIPE_W`, 40: pipe width in pixels.
- `GAP_H`, 120: vertical gap height in each pipe.
- `SCROLL`, 2: pipe leftward movement in pixels per frame.
- `GRAVITY`, 1: downward velocity increment per frame.
- `FLAP_VEL`, 8: upward velocity magnitude set by a flap.
- `clk`  in  1  25 MHz pixel clock, same clock as the sync generator.
- `rst`  in  1  synchronous, active-high reset.
- `hc`  in  10  horizontal count 0..799; active when 144..783.
- `vc`  in  10  vertical count 0..520; active when 31..510.
- `videoen`  in  1  high inside the active area.
- `flap`  in  1  asynchronous push-button, active-high.
- `rgb`  out  8  pixel colour {R[2:0],G[2:0],B[1:0]}, registered.
- `score`  out  8  pipes passed, wraps 255 to 0.
- `dead`  out  1  high while the state is DEAD.

## Operation
- Coordinates: x = hc − 144 and y = vc − 31, both 10-bit. They are meaningful only while `videoen` is high.
- Frame tick: a one-cycle internal pulse when hc==799 and vc==520. All game-state updates happen only on the tick.
- Flap input:
  - Passes through a 2-flop synchronizer, then a rising-edge detect.
  - Each edge sets `flap_pend`; multiple edges between ticks collapse to one.
  - `flap_pend` clears on the tick that consumes it.
- State machine (IDLE, PLAY, DEAD):
  - IDLE: brick at y=232, vel=0, pipe_x=640, gap_y=180. A flap edge moves to PLAY on the next clock and leaves `flap_pend` set.
  - PLAY, on each tick, in this order:
    1. vel = flap_pend ? −FLAP_VEL : min(vel+GRAVITY, 15).
    2. brick_y = brick_y + vel, using the new vel.
    3. If pipe_x < SCROLL: pipe_x=640, gap_y = 60 + lfsr, score+1. Otherwise pipe_x −= SCROLL.
    4. Go to DEAD if new brick_y < 0, new brick_y > 480−BRICK_SIZE, or `hit` is set.
  - DEAD: all state frozen. A flap edge returns to IDLE and restores the IDLE positions. `score` is held in DEAD and cleared on entry to IDLE.
- Widths: brick_y is signed 11-bit; vel is signed 6-bit; pipe_x is unsigned 10-bit in 0..640; gap_y is unsigned 9-bit in 60..315.
- LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1, seed 8'hA5. It advances every clock in every state.
- Pixel classification, per active pixel:
  - brick_px: BRICK_X ≤ x < BRICK_X+BRICK_SIZE and brick_y ≤ y < brick_y+BRICK_SIZE.
  - pipe_px: pipe_x ≤ x < pipe_x+PIPE_W and x < 640, and (y < gap_y or y ≥ gap_y+GAP_H).
- Collision: `hit` sets on any active pixel where brick_px and pipe_px are both true. It is sampled and cleared at each tick.
- Colour priority:
  1. `videoen` low: 8'h00.
  2. brick_px: 8'hE0.
  3. pipe_px: 8'h1C.
  4. Background: 8'h5B in IDLE and PLAY, 8'h49 in DEAD.

## Timing
- `rgb` latency: the colour for (hc, vc) appears on `rgb` exactly 1 clock after `hc`/`vc` are presented.
- Reset values: `rgb`=0, `score`=0, `dead`=0, state=IDLE, brick_y=232, vel=0, pipe_x=640, gap_y=180, lfsr=8'hA5, `hit`=0, `flap_pend`=0, synchronizer flops=0.
- Flap latency: the minimum delay from `flap` rise to a registered edge is 3 clocks.
- Edge coinciding with a tick: an edge arriving on the same clock as a tick is applied at the next tick.
- Tick-cycle render: the tick cycle falls in vertical blank, so state changes never tear within a visible frame.
- Reset mid-frame or mid-game: all state returns to reset values on the next clock; `rgb`=0 that clock.
- `dead` is asserted the clock after the DEAD-transition tick.

## Test plan
- Reset, idle frame: pixel at hc=344, vc=263 gives `rgb`=8'hE0 one clock later; hc=100 gives 8'h00; hc=400, vc=100 gives 8'h5B.
- Single flap in IDLE, then a tick: state becomes PLAY, vel=−8, brick_y=224. The next tick with no flap gives vel=−7, brick_y=217.
- No flaps after entering PLAY via a flap held until the first tick:
  - Brick falls with vel saturating at 15.
  - DEAD exactly on the tick where brick_y exceeds 464.
  - `dead`=1 the clock after that tick.
  - Background reads 8'h49 on the next frame.
- Bench flaps to keep the brick inside the gap:
  - After 320 ticks pipe_x=0.
  - Tick 321: pipe_x=640, `score`=1, new gap_y = 60 + the LFSR value at that clock.
- Brick driven into a pipe column outside the gap:
  - `hit` is set during the frame.
  - DEAD on the following tick; positions frozen on later ticks.
  - A flap edge returns to IDLE with `score`=0 and brick_y=232.
- `rst` pulsed mid-PLAY, mid-line: the next clock shows `rgb`=0 and all state at reset values. Two flap edges between ticks produce only one flap impulse.
